// File: rtl/aes_128_dec.sv
// ---------------------------------------------------------------------------
// aes_128_dec -- iterative AES-128 inverse cipher (FIPS-197 InvCipher).
//
// One ciphertext/key pair is taken per input handshake. The key schedule is
// first stepped forward ten times to reach round key 10. It is then run
// backward one key per cycle while the eleven decryption rounds execute, so
// no round keys are stored. The plaintext is held on the output handshake
// until it is taken.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   ciphertext/key offered
//   in_ready   block can accept (high only while idle)
//   key        cipher key, FIPS byte 0 at [127:120]
//   in_data    ciphertext, byte 0 at [127:120]
//   out_valid  plaintext available
//   out_ready  consumer accepts plaintext
//   out_data   plaintext, byte 0 at [127:120]
//
// Optional build macro: AES_DEC_KEY_CACHE_EN
//   When defined, the last cipher key and its round key 10 are cached. A new
//   block with the same key skips the forward key expansion (latency 11
//   instead of 21).
// ---------------------------------------------------------------------------
module aes_128_dec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {IDLE, KEYX, ROUND, DONE} state_t;

    state_t       state_reg, state_next;
    logic [127:0] st_reg;
    logic [127:0] rk_reg;
    logic [3:0]   cnt_reg;
    logic         cache_hit;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic; the S-boxes are computed rather than tabulated.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Round constant for the step from round key i to round key i+1.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // ------------------------------------------------------------------
    // Key schedule, one step forward and one step backward.
    // ------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  b0, b1, b2, b3;
    logic [127:0] rk_fwd, rk_inv;
    logic [3:0]   inv_idx;

    assign {w0, w1, w2, w3} = rk_reg;

    assign f0 = w0 ^ sub_rot_word(w3) ^ {rcon(cnt_reg), 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    // While rk holds round key 10-cnt, the step back to 9-cnt uses rcon[9-cnt].
    // At cnt=10 the index wraps to 15 and the result is never used.
    assign inv_idx = 4'd9 - cnt_reg;
    assign b3 = w3 ^ w2;
    assign b2 = w2 ^ w1;
    assign b1 = w1 ^ w0;
    assign b0 = w0 ^ sub_rot_word(b3) ^ {rcon(inv_idx), 24'h0};
    assign rk_inv = {b0, b1, b2, b3};

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    // Byte index j = 4*column + row.
    // ------------------------------------------------------------------
    logic [127:0] isr, isb, ark, imc;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            // Row r rotates right by r: output column c comes from column c-r.
            localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
            assign isr[127 - 8*gi -: 8] = st_reg[127 - 8*SRC -: 8];
            assign isb[127 - 8*gi -: 8] = inv_sbox(isr[127 - 8*gi -: 8]);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign imc[127 - 32*gi -: 32] = inv_mix_col(ark[127 - 32*gi -: 32]);
        end
    endgenerate

    assign ark = isb ^ rk_reg;

    // ------------------------------------------------------------------
    // Optional key cache
    // ------------------------------------------------------------------
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key_reg;
    logic [127:0] cache_rk10_reg;
    logic         cache_valid_reg;

    assign cache_hit = cache_valid_reg && (key == cache_key_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key_reg   <= '0;
            cache_rk10_reg  <= '0;
            cache_valid_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid && !cache_hit) begin
            // Invalidate until the new key's round key 10 is known.
            cache_key_reg   <= key;
            cache_valid_reg <= 1'b0;
        end else if (state_reg == KEYX && cnt_reg == 4'd9) begin
            cache_rk10_reg  <= rk_fwd;
            cache_valid_reg <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = cache_hit ? ROUND : KEYX;
            end
            KEYX:  if (cnt_reg == 4'd9)  state_next = ROUND;
            ROUND: if (cnt_reg == 4'd10) state_next = DONE;
            DONE:  if (out_ready)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_reg    <= '0;
            rk_reg    <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        st_reg  <= in_data;
                        cnt_reg <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
                        rk_reg  <= cache_hit ? cache_rk10_reg : key;
`else
                        rk_reg  <= key;
`endif
                    end
                end
                KEYX: begin
                    rk_reg  <= rk_fwd;
                    cnt_reg <= (cnt_reg == 4'd9) ? 4'd0 : cnt_reg + 4'd1;
                end
                ROUND: begin
                    rk_reg <= rk_inv;
                    if (cnt_reg == 4'd0) begin
                        st_reg  <= st_reg ^ rk_reg;
                        cnt_reg <= cnt_reg + 4'd1;
                    end else if (cnt_reg == 4'd10) begin
                        out_data  <= ark;
                        out_valid <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        st_reg  <= imc;
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_dec.sv
// ---------------------------------------------------------------------------
// tb_aes_128_dec -- directed self-checking bench for aes_128_dec using the
// FIPS-197 Appendix B and C.1 vectors. Covers reset values, latency, held
// output under back-pressure, reset mid-operation, input changes while busy,
// and (with AES_DEC_KEY_CACHE_EN) key-cache hit/miss latency.
// ---------------------------------------------------------------------------
module tb_aes_128_dec;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    aes_128_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction. hold = cycles out_ready stays low after
    // out_valid; disturb = change inputs and pulse in_valid while busy.
    task automatic run(input string name, input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] exp, input int exp_lat, input int hold,
                       input bit disturb);
        int           n;
        bit           ready_low;
        bit           stable;
        logic [127:0] held;
        out_ready = (hold == 0);
        key       = k;
        in_data   = d;
        in_valid  = 1'b1;
        check({name, ".in_ready_idle"}, 128'(in_ready), 128'(1));
        tick();                                   // accepting edge
        in_valid  = 1'b0;
        key       = ~k;
        in_data   = ~d;
        n         = 0;
        ready_low = 1'b1;
        while (n < 40) begin
            if (disturb && n == 3) begin
                in_valid = 1'b1;
                key      = K1 ^ K2;
                in_data  = C1;
            end
            if (disturb && n == 5) in_valid = 1'b0;
            tick();
            n++;
            if (in_ready !== 1'b0) ready_low = 1'b0;
            if (out_valid === 1'b1) break;
        end
        in_valid = 1'b0;
        check({name, ".latency"}, 128'(n), 128'(exp_lat));
        check({name, ".in_ready_busy"}, 128'(ready_low), 128'(1));
        check({name, ".out_data"}, out_data, exp);
        held   = out_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({name, ".held_stable"}, 128'(stable), 128'(1));
        out_ready = 1'b1;
        tick();
        check({name, ".out_valid_drop"}, 128'(out_valid), 128'(0));
        check({name, ".in_ready_back"}, 128'(in_ready), 128'(1));
        $display("txn %s: key=%h ct=%h pt=%h latency=%0d", name, k, d, held, n);
    endtask

    initial begin
        bit quiet;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        key       = '0;
        in_data   = '0;
        #1;
        check("reset.in_ready", 128'(in_ready), 128'(1));
        check("reset.out_valid", 128'(out_valid), 128'(0));
        check("reset.out_data", out_data, 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 Appendix B and C.1
        run("fips_b", K1, C1, P1, 21, 0, 1'b0);
        run("fips_c1", K2, C2, P2, 21, 0, 1'b0);

        // Back-pressure: out_ready low for 5 cycles after out_valid
        run("hold5", K1, C1, P1, 21, 5, 1'b0);

        // Reset while ROUND cnt=4 (accept + 10 KEYX + 4 ROUND edges)
        key      = K2;
        in_data  = C2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 128'(out_valid), 128'(0));
        check("midrst.in_ready", 128'(in_ready), 128'(1));
        check("midrst.out_data", out_data, 128'(0));
        tick();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check("midrst.no_pulse", 128'(quiet), 128'(1));
        $display("txn midrst: reset at ROUND cnt=4, partial result discarded");
        run("after_rst", K1, C1, P1, 21, 0, 1'b0);

        // Inputs changed and in_valid pulsed during KEYX
        run("keyx_disturb", K2, C2, P2, 21, 0, 1'b1);

        // Key reuse back-to-back, then a different key
        run("reuse_a", K1, C1, P1, 21, 0, 1'b0);
        run("reuse_b", K1, C1, P1, HIT_LAT, 0, 1'b0);
        run("new_key", K2, C2, P2, 21, 0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
